// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: buffers hold/reset/set/toggle commands in a FIFO,
// drives j/k for rpt+1 cycles per command and checks q feedback against a reference model.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rpt,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    input  logic                     q_fb,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    output logic                     state_dbg
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               q_exp;

    logic [CNT_W+1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_rpt;

    // Handshake: a command transfers on any edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on occupancy, never on cmd_valid or a same-edge pop.
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = !empty && ((state == IDLE) || (cnt == '0));
    assign head_op   = mem[rd_ptr][CNT_W+1:CNT_W];
    assign head_rpt  = mem[rd_ptr][CNT_W-1:0];
    assign level     = count;
    assign busy      = (state == DRIVE) || !empty;
    assign state_dbg = (state == DRIVE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_rpt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            cnt   <= '0;
            q_exp <= 1'b0;
            err   <= 1'b0;
        end else begin
            // Reference flip-flop follows the j/k currently presented to the real one.
            case ({j, k})
                2'b01:   q_exp <= 1'b0;
                2'b10:   q_exp <= 1'b1;
                2'b11:   q_exp <= ~q_exp;
                default: q_exp <= q_exp;
            endcase
            if (q_fb != q_exp) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        j     <= head_op[1];
                        k     <= head_op[0];
                        cnt   <= head_rpt;
                        state <= DRIVE;
                    end else begin
                        j <= 1'b0;
                        k <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (pop) begin
                        j   <= head_op[1];
                        k   <= head_op[0];
                        cnt <= head_rpt;
                    end else begin
                        j     <= 1'b0;
                        k     <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: a JK flip-flop closes the q_fb loop, and a queue-based
// command model predicts j/k, occupancy, busy and the sticky error flag every cycle.
module tb_jk_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_rpt = '0;
    logic             cmd_ready;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             busy;
    logic [LW-1:0]    level;
    logic             err;
    logic             state_dbg;

    logic             q_ff;
    logic             fault = 1'b0;

    // Model state: pending commands, the command on the outputs and its cycles left.
    logic [CNT_W+1:0] exp_q[$];
    logic [1:0]       cur_op = 2'b00;
    int               cur_left = 0;
    logic             m_q = 1'b0;
    logic             m_err = 1'b0;
    logic [1:0]       trace[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_rpt   (cmd_rpt),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .level     (level),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // The JK flip-flop stage being driven; it shares the sequencer reset.
    always @(posedge clk) begin
        if (!rst) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end
    assign q_fb = fault ? 1'b0 : q_ff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_fault(input logic f);
        fault = f;
        #1;
    endtask

    // One clock: drive inputs, advance the model across the edge, check after it.
    task automatic cycle(input logic r, input logic v, input logic [1:0] op,
                         input logic [CNT_W-1:0] rpt, output logic accepted);
        logic [1:0]       jk_now;
        logic [CNT_W+1:0] e;
        rst = r; cmd_valid = v; cmd_op = op; cmd_rpt = rpt;
        accepted = r && v && (exp_q.size() < DEPTH);
        if (!r) begin
            exp_q.delete();
            cur_left = 0; cur_op = 2'b00; m_q = 1'b0; m_err = 1'b0;
        end else begin
            jk_now = (cur_left > 0) ? cur_op : 2'b00;
            if (q_fb !== m_q) m_err = 1'b1;
            case (jk_now)
                2'b01:   m_q = 1'b0;
                2'b10:   m_q = 1'b1;
                2'b11:   m_q = ~m_q;
                default: m_q = m_q;
            endcase
            if (cur_left <= 1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur_op = e[CNT_W+1:CNT_W];
                cur_left = int'(e[CNT_W-1:0]) + 1;
            end else if (cur_left > 0) begin
                cur_left--;
            end
            if (accepted) exp_q.push_back({op, rpt});
        end
        @(posedge clk);
        @(negedge clk);
        trace.push_back({j, k});
        check("j", j, (cur_left > 0) ? cur_op[1] : 1'b0);
        check("k", k, (cur_left > 0) ? cur_op[0] : 1'b0);
        check("level", level, exp_q.size());
        check("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
        check("busy", busy, (cur_left > 0) || (exp_q.size() > 0));
        check("err", err, m_err);
        check("state", state_dbg, cur_left > 0);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'b00, '0, acc);
    endtask

    // Holds cmd_valid until the command is taken, within a cycle budget.
    task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] rpt);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            cycle(1'b1, 1'b1, op, rpt, acc);
            n++;
        end
        check("push_accept", acc, 1'b1);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, '0, acc);
    endtask

    logic [1:0] bb_exp [10];
    logic       acc_r;

    initial begin
        @(negedge clk);

        // Reset, then stay idle.
        do_reset(2);
        idle(5);

        // Single set with rpt=2.
        push_cmd(2'b10, 4'd2);
        idle(6);

        // Back-to-back commands; j/k must follow the expected sequence with no gap.
        bb_exp = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        trace.delete();
        push_cmd(2'b10, 4'd0);
        push_cmd(2'b00, 4'd1);
        push_cmd(2'b01, 4'd0);
        push_cmd(2'b11, 4'd3);
        idle(6);
        for (int i = 0; i < 10; i++) check("bb_seq", trace[i], bb_exp[i]);
        idle(2);

        // Fill the FIFO behind a long command; fifth waits for the next pop.
        push_cmd(2'b11, 4'd15);
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b01, 4'd2);
        push_cmd(2'b11, 4'd0);
        push_cmd(2'b00, 4'd1);
        check("full_level", level, 4);
        check("full_ready", cmd_ready, 1'b0);
        push_cmd(2'b10, 4'd3);
        idle(30);

        // Broken feedback: err must rise and stay until reset.
        set_fault(1'b1);
        push_cmd(2'b10, 4'd0);
        idle(4);
        push_cmd(2'b11, 4'd1);
        idle(4);
        check("err_sticky", err, 1'b1);
        do_reset(1);
        set_fault(1'b0);
        idle(2);

        // Reset during a long toggle with two commands queued.
        push_cmd(2'b11, 4'd10);
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b01, 4'd1);
        idle(3);
        do_reset(1);
        check("rst_level", level, 0);
        check("rst_state", state_dbg, 1'b0);
        idle(15);

        // Randomized traffic with occasional resets and feedback faults.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) set_fault(~fault);
            if ($urandom_range(0, 249) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                cycle(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 3)),
                      acc_r);
            end
        end
        set_fault(1'b0);
        idle(80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Upstream driver for the JK flip-flop stage. It accepts JK operation commands (hold, reset, set, toggle) over a valid/ready handshake and buffers them in a small FIFO. It drives the flip-flop's j/k inputs for a programmable number of cycles per command. It also keeps a reference model of the flip-flop output and flags any mismatch on the q feedback.

Parameters:
DEPTH, 4, command FIFO depth in entries; must be a power of 2 and at least 2.
CNT_W, 4, width of the per-command repeat field.

Ports:
clk  input  1  system clock; all logic updates on the rising edge.
rst  input  1  synchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_op  input  2  operation: 00 hold, 01 reset, 10 set, 11 toggle.
cmd_rpt  input  CNT_W  repeat count; the command is applied for cmd_rpt+1 cycles.
cmd_ready  output  1  FIFO can accept a command.
j  output  1  J input to the flip-flop, registered.
k  output  1  K input to the flip-flop, registered.
q_fb  input  1  q output returned from the flip-flop.
busy  output  1  high in DRIVE state or when the FIFO is non-empty.
level  output  $clog2(DEPTH)+1  current FIFO occupancy.
err  output  1  sticky q mismatch flag.

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - FIFO flushed, level=0.
  - FSM to IDLE.
  - j=0, k=0, err=0, busy=0, internal q_exp=0.
  - Applies mid-command: the command in progress is abandoned.
  - The flip-flop shares rst, so its q is 0 after reset.
- Handshake and FIFO:
  - cmd_ready = !full, combinational from level.
  - A push occurs on an edge with cmd_valid && cmd_ready; {cmd_op, cmd_rpt} is stored.
  - There is no bypass: a push into an empty FIFO is poppable from the next edge.
  - When full, cmd_ready=0 even if a pop occurs on the same edge.
  - Push and pop on the same edge with the FIFO not full leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM, two states:
  - IDLE: j=k=0. If the FIFO is non-empty, pop at the edge: load op_reg and cnt=rpt, drive j=op[1] and k=op[0] from that edge, go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: at each edge, if cnt!=0 then cnt-=1 and j/k are held.
  - DRIVE, cnt==0, FIFO non-empty: pop the next command back-to-back with no idle gap, load it, update j/k, stay in DRIVE.
  - DRIVE, cnt==0, FIFO empty: j=k=0, go to IDLE.
- Latency: a command accepted at edge E drives j/k from edge E+1 (when idle) for exactly rpt+1 consecutive cycles.
- Reference model: q_exp updates on the same edges as the flip-flop, using the currently registered j/k.
  - 00: q_exp holds.
  - 01: q_exp = 0.
  - 10: q_exp = 1.
  - 11: q_exp toggles.
- Checker:
  - Each edge with rst=1, if q_fb != q_exp, err <= 1.
  - err stays set until reset; it has no other clear.
- Width rules: cnt is CNT_W bits. rpt=max gives 2^CNT_W cycles, and the counter never wraps.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 with no commands → j=k=0, level=0, cmd_ready=1, busy=0, err=0 throughout.
- Single set: push op=10, rpt=2 at edge E → j=1, k=0 for edges E+1..E+3, then j=k=0 and IDLE. With a correct flip-flop attached, q_fb=1 from edge E+2 and err stays 0.
- Back-to-back sequence: push set/rpt0, hold/rpt1, reset/rpt0, toggle/rpt3 with no gaps → j/k sequence 10,00,00,01,11,11,11,11 with no idle cycle. q_fb follows 1,1,1,0,1,0,1,0 and err stays 0.
- FIFO full: with DEPTH=4, push 5 commands while the first (rpt=15) is driving → cmd_ready drops after the 4th is buffered and level=4. The 5th is accepted only after the next pop, and all 5 execute in order.
- Mismatch detection: tie q_fb=0 and push set/rpt0 → err=1 one edge after the flip-flop should have gone to 1. err stays 1 through later commands and clears only on rst=0.
- Reset mid-operation: assert rst=0 during a toggle/rpt=10 with 2 queued commands → next cycle j=k=0, level=0, FSM IDLE, err=0. The queued commands are never executed after rst=1.
